// File: rtl/fb_scanout_if.sv
// Scan-out bus: VGA next-pixel request, RAM read port and colour output.
// slave = scan-out reader, master = VGA generator / RAM side.
interface fb_scanout_if;
  logic        PIX_EN;
  logic [9:0]  NEXT_X;
  logic [9:0]  NEXT_Y;
  logic [1:0]  IMAGE_STATE;
  logic [16:0] R_ADDR;
  logic [7:0]  RAM_Q;
  logic [7:0]  COLOR_OUT;
  logic        COLOR_VALID;
  logic        IN_WINDOW;

  modport master (
    output PIX_EN, NEXT_X, NEXT_Y, IMAGE_STATE, RAM_Q,
    input  R_ADDR, COLOR_OUT, COLOR_VALID, IN_WINDOW
  );

  modport slave (
    input  PIX_EN, NEXT_X, NEXT_Y, IMAGE_STATE, RAM_Q,
    output R_ADDR, COLOR_OUT, COLOR_VALID, IN_WINDOW
  );
endinterface

// File: rtl/fb_scanout.sv
// Framebuffer scan-out reader: centred zoom window, counter-based RAM addressing,
// latency-aligned colour output. Optional window border ring: FB_SCANOUT_BORDER_EN.
module fb_scanout #(
  parameter int RD_LAT   = 2,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic         CLK,
  input  logic         RESET,
  fb_scanout_if.slave  bus
);

  typedef enum logic {SYNC = 1'b0, ACTIVE = 1'b1} state_t;

  function automatic int zoom_w(input int s);
    case (s)
      0:       return 160;
      1:       return 320;
      2:       return 80;
      default: return 40;
    endcase
  endfunction

  function automatic int zoom_h(input int s);
    case (s)
      0:       return 120;
      1:       return 240;
      2:       return 60;
      default: return 30;
    endcase
  endfunction

  // Window geometry per zoom state; all entries are elaboration-time constants.
  logic [10:0] x_lo_tab [4];
  logic [10:0] x_hi_tab [4];
  logic [10:0] y_lo_tab [4];
  logic [10:0] y_hi_tab [4];
  logic [16:0] last_tab [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_geom
    assign x_lo_tab[gi] = 11'((H_ACTIVE - zoom_w(gi)) / 2);
    assign x_hi_tab[gi] = 11'((H_ACTIVE - zoom_w(gi)) / 2 + zoom_w(gi));
    assign y_lo_tab[gi] = 11'((V_ACTIVE - zoom_h(gi)) / 2);
    assign y_hi_tab[gi] = 11'((V_ACTIVE - zoom_h(gi)) / 2 + zoom_h(gi));
    assign last_tab[gi] = 17'(zoom_w(gi) * zoom_h(gi) - 1);
  end

  state_t      state_reg, state_next;
  logic [1:0]  zoom_reg, zoom_next;
  logic [16:0] cnt_reg, cnt_next;
  logic [16:0] r_addr_reg, r_addr_next;

  logic        frame_start;
  logic        active_eff;
  logic [1:0]  zoom_eff;
  logic [16:0] cnt_eff;
  logic [10:0] x_pos, y_pos;
  logic        in_x, in_y, ring_x, ring_y;
  logic        in_win;
  logic        ring;

  assign frame_start = bus.PIX_EN && (bus.NEXT_X == 10'd0) && (bus.NEXT_Y == 10'd0);
  // The frame-start strobe already sees the new frame's zoom and a cleared counter.
  assign active_eff  = (state_reg == ACTIVE) || frame_start;
  assign zoom_eff    = frame_start ? bus.IMAGE_STATE : zoom_reg;
  assign cnt_eff     = frame_start ? 17'd0 : cnt_reg;

  assign x_pos  = {1'b0, bus.NEXT_X};
  assign y_pos  = {1'b0, bus.NEXT_Y};
  assign in_x   = (x_pos >= x_lo_tab[zoom_eff]) && (x_pos < x_hi_tab[zoom_eff]);
  assign in_y   = (y_pos >= y_lo_tab[zoom_eff]) && (y_pos < y_hi_tab[zoom_eff]);
  // Box grown by one pixel on every side; +1 on the left keeps it underflow-free.
  assign ring_x = ((x_pos + 11'd1) >= x_lo_tab[zoom_eff]) && (x_pos <= x_hi_tab[zoom_eff]);
  assign ring_y = ((y_pos + 11'd1) >= y_lo_tab[zoom_eff]) && (y_pos <= y_hi_tab[zoom_eff]);
  assign in_win = active_eff && in_x && in_y;

`ifdef FB_SCANOUT_BORDER_EN
  assign ring = active_eff && !in_win && ring_x && ring_y;
`else
  assign ring = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg  <= SYNC;
      zoom_reg   <= 2'b00;
      cnt_reg    <= 17'd0;
      r_addr_reg <= 17'd0;
    end else begin
      state_reg  <= state_next;
      zoom_reg   <= zoom_next;
      cnt_reg    <= cnt_next;
      r_addr_reg <= r_addr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    zoom_next   = zoom_reg;
    cnt_next    = cnt_reg;
    r_addr_next = r_addr_reg;
    if (frame_start) begin
      state_next = ACTIVE;
      zoom_next  = bus.IMAGE_STATE;
      cnt_next   = 17'd0;
    end
    if (bus.PIX_EN && in_win) begin
      r_addr_next = cnt_eff;
      cnt_next    = (cnt_eff == last_tab[zoom_eff]) ? cnt_eff : cnt_eff + 17'd1;
    end
  end

  // Tag pipeline: stage 0 sits beside R_ADDR, stage RD_LAT lines up with RAM_Q.
  logic tag_valid_reg [RD_LAT+1];
  logic tag_win_reg   [RD_LAT+1];
  logic tag_ring_reg  [RD_LAT+1];

  for (genvar gi = 0; gi <= RD_LAT; gi++) begin : g_tag
    if (gi == 0) begin : g_head
      always_ff @(posedge CLK) begin
        if (RESET) begin
          tag_valid_reg[gi] <= 1'b0;
          tag_win_reg[gi]   <= 1'b0;
          tag_ring_reg[gi]  <= 1'b0;
        end else begin
          tag_valid_reg[gi] <= bus.PIX_EN;
          tag_win_reg[gi]   <= in_win;
          tag_ring_reg[gi]  <= ring;
        end
      end
    end else begin : g_body
      always_ff @(posedge CLK) begin
        if (RESET) begin
          tag_valid_reg[gi] <= 1'b0;
          tag_win_reg[gi]   <= 1'b0;
          tag_ring_reg[gi]  <= 1'b0;
        end else begin
          tag_valid_reg[gi] <= tag_valid_reg[gi-1];
          tag_win_reg[gi]   <= tag_win_reg[gi-1];
          tag_ring_reg[gi]  <= tag_ring_reg[gi-1];
        end
      end
    end
  end

  logic [7:0] color_out_reg;
  logic       color_valid_reg;
  logic       in_window_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      color_out_reg   <= 8'h00;
      color_valid_reg <= 1'b0;
      in_window_reg   <= 1'b0;
    end else begin
      color_valid_reg <= tag_valid_reg[RD_LAT];
      if (tag_valid_reg[RD_LAT]) begin
        in_window_reg <= tag_win_reg[RD_LAT];
        if (tag_win_reg[RD_LAT])
          color_out_reg <= bus.RAM_Q;
        else if (tag_ring_reg[RD_LAT])
          color_out_reg <= 8'hFF;
        else
          color_out_reg <= 8'h00;
      end
    end
  end

  assign bus.R_ADDR      = r_addr_reg;
  assign bus.COLOR_OUT   = color_out_reg;
  assign bus.COLOR_VALID = color_valid_reg;
  assign bus.IN_WINDOW   = in_window_reg;

endmodule
